// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor computing a - b - bin, LSB first, one bit
//   per clock. The operands and bin are captured on start. The result appears
//   on diff/bout only when the operation completes.
//
// Ports
//   clk    : clock; all state updates on its rising edge
//   rst_n  : asynchronous active-low reset
//   start  : begin one subtraction (sampled only while idle)
//   a, b   : minuend / subtrahend, WIDTH bits
//   bin    : borrow-in
//   diff   : registered result (a - b - bin) mod 2^WIDTH
//   bout   : registered borrow-out (a < b + bin, unsigned)
//   busy   : high while an operation is in progress (SHIFT or DONE)
//   done   : one-cycle pulse in the cycle after diff/bout are updated
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;

    logic               a_bit;
    logic               b_bit;
    logic               d_bit;
    logic               br_next;
    logic [WIDTH-1:0]   res_shifted;

    always_comb begin
        // Full-subtractor cell on the current LSBs of the operand shifters.
        a_bit       = a_sh_q[0];
        b_bit       = b_sh_q[0];
        d_bit       = a_bit ^ b_bit ^ br_q;
        br_next     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        res_shifted = {d_bit, res_q[WIDTH-1:1]};

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d  = res_shifted;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + CNT_W'(1);
                // The last bit's result is taken straight from the shifted
                // value so diff is loaded on the same edge that enters DONE.
                if (cnt_q == LAST_BIT) begin
                    diff_d  = res_shifted;
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=4): directed vector
//   table, hand-written corner sequences (start during operation, reset
//   mid-operation), randomized operations and an exhaustive back-to-back sweep
//   checked against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;

    int tests;
    int fails;
    int cyc;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vbin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
    } vec_t;

    // Reference: {bout, diff} = (a - b - bin) mod 2^(W+1).
    function automatic logic [W:0] ref_sub(input int ra, input int rb, input int rbin);
        int r;
        r = ra - rb - rbin;
        r = (r + 4 * (1 << (W + 1))) % (1 << (W + 1));
        return (W + 1)'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Runs one operation from idle. lat is the rising edge (counted from the
    // capture edge = 0) that samples done high; busy_cnt counts busy cycles.
    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                      output logic [W-1:0] od, output logic ob, output int lat,
                      output int busy_cnt, output int done_cnt, output int hold_bad);
        logic [W-1:0] prev_d;
        logic         prev_b;
        @(negedge clk);
        prev_d = diff;
        prev_b = bout;
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        lat = -1; busy_cnt = 0; done_cnt = 0; hold_bad = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end else if (lat < 0 && (diff !== prev_d || bout !== prev_b)) begin
                hold_bad++;
            end
        end
        od = diff;
        ob = bout;
    endtask

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] od;
        logic         ob;
        int           lat, bcnt, dcnt, hbad;
        logic [W:0]   expv;
        int           last_done_cyc;
        int           got_done;

        tests = 0;
        fails = 0;

        vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
        vecs[1] = '{4'd3,  4'd9,  1'b0, 4'd10, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd5,  4'd2,  1'b1, 4'd2,  1'b0};
        vecs[5] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #23;
        check("reset_diff", 32'(diff), 0);
        check("reset_bout", 32'(bout), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            op(vecs[i].va, vecs[i].vb, vecs[i].vbin, od, ob, lat, bcnt, dcnt, hbad);
            check($sformatf("vec%0d_diff", i), 32'(od), 32'(vecs[i].exp_diff));
            check($sformatf("vec%0d_bout", i), 32'(ob), 32'(vecs[i].exp_bout));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(W + 1));
            check($sformatf("vec%0d_done_pulses", i), 32'(dcnt), 1);
            check($sformatf("vec%0d_diff_hold", i), 32'(hbad), 0);
        end

        // start re-asserted during SHIFT and DONE with changed operands
        @(negedge clk);
        a = 4'd8; b = 4'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = '0; b = '0;
        bcnt = 0; dcnt = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) dcnt++;
            start = (k >= 2 && k <= 4) ? 1'b1 : 1'b0;
        end
        check("ignore_start_diff", 32'(diff), 7);
        check("ignore_start_bout", 32'(bout), 0);
        check("ignore_start_done_pulses", 32'(dcnt), 1);
        check("ignore_start_busy_cycles", 32'(bcnt), 32'(W + 1));

        // reset two edges after the capture edge
        @(negedge clk);
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_diff", 32'(diff), 0);
        check("midreset_bout", 32'(bout), 0);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postreset_busy", 32'(busy), 0);
        check("postreset_diff", 32'(diff), 0);
        op(4'd5, 4'd2, 1'b0, od, ob, lat, bcnt, dcnt, hbad);
        check("postreset_op_diff", 32'(od), 3);
        check("postreset_op_bout", 32'(ob), 0);
        check("postreset_op_latency", 32'(lat), 32'(W + 1));

        // randomized operations with random idle gaps
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            int           gap;
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) @(negedge clk);
            op(ra, rb, rbin, od, ob, lat, bcnt, dcnt, hbad);
            expv = ref_sub(int'(ra), int'(rb), int'(rbin));
            check("rand_result", 32'({ob, od}), 32'(expv));
            check("rand_diff_hold", 32'(hbad), 0);
        end

        // exhaustive sweep, start held high so every idle cycle starts an op
        @(negedge clk);
        last_done_cyc = -1;
        start = 1'b1;
        for (int v = 0; v < (1 << (2 * W + 1)); v++) begin
            logic [W-1:0] ea, eb;
            logic         ebin;
            ea   = W'(v >> (W + 1));
            eb   = W'(v >> 1);
            ebin = 1'(v);
            for (int t = 0; t < 10 && busy; t++) @(negedge clk);
            a = ea; b = eb; bin = ebin;
            @(posedge clk);
            #1;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            got_done = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (done) begin
                    got_done = 1;
                    break;
                end
            end
            if (got_done == 0) begin
                check("exh_done_timeout", 0, 1);
            end else begin
                expv = ref_sub(int'(ea), int'(eb), int'(ebin));
                check($sformatf("exh_a%0d_b%0d_bin%0d", ea, eb, ebin), 32'({bout, diff}), 32'(expv));
                if (last_done_cyc >= 0)
                    check("exh_throughput", 32'(cyc - last_done_cyc), 32'(W + 2));
                last_done_cyc = cyc;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("final_idle_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
